// File: rtl/adc_spi_rx_if.sv
// adc_spi_rx_if: conversion-request, ADC serial link and sample-output bundle of the dual-channel ADC receiver.
interface adc_spi_rx_if;
   logic        Init;
   logic        SPI_MISO;
   logic        ADC_Conv;
   logic        SPI_CLK;
   logic [13:0] Data_A;
   logic [13:0] Data_B;
   logic        Data_Valid;
   logic        Busy;
   modport slave (
      input  Init, SPI_MISO,
      output ADC_Conv, SPI_CLK, Data_A, Data_B, Data_Valid, Busy
   );
   modport master (
      output Init, SPI_MISO,
      input  ADC_Conv, SPI_CLK, Data_A, Data_B, Data_Valid, Busy
   );
endinterface

// File: rtl/adc_spi_rx.sv
// adc_spi_rx: starts a conversion, clocks a 34-bit frame from the ADC and delivers two 14-bit samples.
module adc_spi_rx #(
   parameter int CLK_DIV = 4
) (
   input logic        clk,
   input logic        rst,
   adc_spi_rx_if.slave bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CONV  = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [8:0] C_HALF  = 9'(CLK_DIV);
   localparam logic [8:0] C_LAST  = 9'(2 * CLK_DIV - 1);
   localparam logic [5:0] C_BITS  = 6'd33;
   logic [1:0]  r_state;
   logic [8:0]  r_cnt;
   logic [5:0]  r_bit;
   logic [27:0] r_sr;
   logic        r_conv;
   logic        r_sclk;
   logic        r_valid;
   logic        r_busy;
   logic [13:0] r_data_a;
   logic [13:0] r_data_b;
   logic        w_cnt_end;
   logic        w_sample;
   logic        w_data_bit;
   assign w_cnt_end  = r_cnt == C_LAST;
   // Sampling happens on the very edge that raises the registered SPI_CLK.
   assign w_sample   = r_state == S_SHIFT && r_cnt == C_HALF;
   assign w_data_bit = (r_bit >= 6'd2 && r_bit <= 6'd15) || (r_bit >= 6'd18 && r_bit <= 6'd31);
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_bit    <= '0;
         r_sr     <= '0;
         r_conv   <= 1'b0;
         r_sclk   <= 1'b0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_data_a <= '0;
         r_data_b <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.Init) r_state <= S_CONV;
               r_cnt <= '0;
               r_bit <= '0;
            end
            S_CONV: begin
               r_cnt <= w_cnt_end ? 9'd0 : r_cnt + 9'd1;
               if (w_cnt_end) r_state <= S_SHIFT;
            end
            S_SHIFT: begin
               r_cnt <= w_cnt_end ? 9'd0 : r_cnt + 9'd1;
               if (w_cnt_end) r_bit <= (r_bit == C_BITS) ? 6'd0 : r_bit + 6'd1;
               if (w_cnt_end && r_bit == C_BITS) r_state <= S_DONE;
               if (w_sample && w_data_bit) r_sr <= {r_sr[26:0], bus.SPI_MISO};
            end
            S_DONE: r_state <= S_IDLE;
         endcase
         r_conv  <= r_state == S_CONV;
         r_sclk  <= r_state == S_SHIFT && r_cnt >= C_HALF;
         r_valid <= r_state == S_DONE;
         r_busy  <= r_state != S_IDLE;
         if (r_state == S_DONE) begin
            r_data_a <= r_sr[27:14];
            r_data_b <= r_sr[13:0];
         end
      end
   end
   assign bus.ADC_Conv   = r_conv;
   assign bus.SPI_CLK    = r_sclk;
   assign bus.Data_A     = r_data_a;
   assign bus.Data_B     = r_data_b;
   assign bus.Data_Valid = r_valid;
   assign bus.Busy       = r_busy;
endmodule

// File: tb/tb_adc_spi_rx.sv
// tb_adc_spi_rx: directed bench for adc_spi_rx at CLK_DIV=4 and CLK_DIV=1 with a behavioural ADC.
module tb_adc_spi_rx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   adc_spi_rx_if if4 ();
   adc_spi_rx_if if1 ();
   adc_spi_rx #(.CLK_DIV(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
   adc_spi_rx #(.CLK_DIV(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
   int errs = 0;
   int checks = 0;
   int cyc = 0;
   int e0 = 0;
   always @(posedge clk) cyc <= cyc + 1;
   logic [33:0] fr4 = '1;
   logic [33:0] fr1 = '1;
   logic [5:0]  k4 = '0;
   logic [5:0]  k1 = '0;
   assign if4.SPI_MISO = (k4 <= 6'd33) ? fr4[6'd33 - k4] : 1'b0;
   assign if1.SPI_MISO = (k1 <= 6'd33) ? fr1[6'd33 - k1] : 1'b0;
   always @(posedge if4.ADC_Conv or negedge if4.SPI_CLK) k4 <= if4.ADC_Conv ? 6'd0 : k4 + 6'd1;
   always @(posedge if1.ADC_Conv or negedge if1.SPI_CLK) k1 <= if1.ADC_Conv ? 6'd0 : k1 + 6'd1;
   logic [31:0] o4, o1;
   assign o4 = {if4.ADC_Conv, if4.SPI_CLK, if4.Data_A, if4.Data_B, if4.Data_Valid, if4.Busy};
   assign o1 = {if1.ADC_Conv, if1.SPI_CLK, if1.Data_A, if1.Data_B, if1.Data_Valid, if1.Busy};
   int conv4 = 0, rise4 = 0, dv4 = 0, dvc4 = 0, b0_4 = 0;
   int conv1 = 0, rise1 = 0, dv1 = 0, dvc1 = 0;
   logic ps4 = 1'b0, ps1 = 1'b0;
   always @(negedge clk) begin
      if (if4.ADC_Conv === 1'b1) conv4 <= conv4 + 1;
      if (if4.SPI_CLK === 1'b1 && !ps4) rise4 <= rise4 + 1;
      ps4 <= if4.SPI_CLK === 1'b1;
      if (if4.Data_Valid === 1'b1) begin
         dv4  <= dv4 + 1;
         dvc4 <= cyc;
      end
      if (if4.Busy === 1'b0) b0_4 <= b0_4 + 1;
      if (if1.ADC_Conv === 1'b1) conv1 <= conv1 + 1;
      if (if1.SPI_CLK === 1'b1 && !ps1) rise1 <= rise1 + 1;
      ps1 <= if1.SPI_CLK === 1'b1;
      if (if1.Data_Valid === 1'b1) begin
         dv1  <= dv1 + 1;
         dvc1 <= cyc;
      end
   end
   function automatic logic [33:0] frame(input logic [13:0] a, input logic [13:0] b, input logic z);
      return {{2{z}}, a, {2{z}}, b, {2{z}}};
   endfunction
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic start(input bit one, input logic [33:0] f);
      if (one) begin
         fr1 = f;
         if1.Init = 1'b1;
      end else begin
         fr4 = f;
         if4.Init = 1'b1;
      end
      tick();
      e0 = cyc;
      if1.Init = 1'b0;
      if4.Init = 1'b0;
   endtask
   task automatic wait_dv(input bit one, input int base, input int lim);
      int n = 0;
      while ((one ? dv1 : dv4) == base && n < lim) begin
         tick();
         n++;
      end
      chk(one ? "dv1_wait" : "dv4_wait", 32'(n < lim), 32'd1);
   endtask
   initial begin
      int c, r, d, b, t, n;
      if4.Init = 1'b1;
      if1.Init = 1'b1;
      rst = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_out4", o4, 32'd0);
         chk("rst_out1", o1, 32'd0);
      end
      tick();
      rst = 1'b0;
      if4.Init = 1'b0;
      if1.Init = 1'b0;
      repeat (3) tick();
      chk("idle_out4", o4, 32'd0);
      c = conv4;
      r = rise4;
      d = dv4;
      start(1'b0, frame(14'h2155, 14'h0AAA, 1'b0));
      wait_dv(1'b0, d, 400);
      repeat (20) tick();
      chk("conv_len4", 32'(conv4 - c), 32'd8);
      chk("sclk_rises4", 32'(rise4 - r), 32'd34);
      chk("dv_pulses4", 32'(dv4 - d), 32'd1);
      chk("latency4", 32'(dvc4 - e0), 32'd281);
      chk("data_a4", 32'(if4.Data_A), 32'h2155);
      chk("data_b4", 32'(if4.Data_B), 32'h0AAA);
      chk("busy_after4", 32'(if4.Busy), 32'd0);
      d = dv4;
      start(1'b0, frame(14'h3FFF, 14'h0000, 1'b1));
      wait_dv(1'b0, d, 400);
      chk("hiz_a4", 32'(if4.Data_A), 32'h3FFF);
      chk("hiz_b4", 32'(if4.Data_B), 32'h0000);
      repeat (50) tick();
      chk("hold_a4", 32'(if4.Data_A), 32'h3FFF);
      d = dv4;
      start(1'b0, frame(14'h0F0F, 14'h30C3, 1'b0));
      repeat (49) tick();
      if4.Init = 1'b1;
      tick();
      if4.Init = 1'b0;
      repeat (149) tick();
      if4.Init = 1'b1;
      tick();
      if4.Init = 1'b0;
      repeat (700) tick();
      chk("busy_init_ignored", 32'(dv4 - d), 32'd1);
      chk("busy_a4", 32'(if4.Data_A), 32'h0F0F);
      chk("busy_b4", 32'(if4.Data_B), 32'h30C3);
      d = dv4;
      if4.Init = 1'b1;
      wait_dv(1'b0, d, 400);
      b = b0_4;
      t = dvc4;
      wait_dv(1'b0, d + 1, 400);
      chk("gap_busy_low", 32'(b0_4 - b), 32'd1);
      chk("frame_period4", 32'(dvc4 - t), 32'd282);
      if4.Init = 1'b0;
      repeat (300) tick();
      d = dv4;
      r = rise4;
      start(1'b0, frame(14'h1555, 14'h2AAA, 1'b0));
      n = 0;
      while (rise4 - r < 11 && n < 200) begin
         tick();
         n++;
      end
      chk("reach_bit10", 32'(n < 200), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid4", o4, 32'd0);
      tick();
      rst = 1'b0;
      repeat (400) tick();
      chk("abort_no_dv", 32'(dv4 - d), 32'd0);
      d = dv4;
      start(1'b0, frame(14'h1234, 14'h2ABC, 1'b0));
      wait_dv(1'b0, d, 400);
      chk("after_rst_a4", 32'(if4.Data_A), 32'h1234);
      chk("after_rst_b4", 32'(if4.Data_B), 32'h2ABC);
      c = conv1;
      r = rise1;
      d = dv1;
      start(1'b1, frame(14'h2C3A, 14'h1F05, 1'b1));
      wait_dv(1'b1, d, 200);
      repeat (10) tick();
      chk("conv_len1", 32'(conv1 - c), 32'd2);
      chk("sclk_rises1", 32'(rise1 - r), 32'd34);
      chk("dv_pulses1", 32'(dv1 - d), 32'd1);
      chk("latency1", 32'(dvc1 - e0), 32'd71);
      chk("data_a1", 32'(if1.Data_A), 32'h2C3A);
      chk("data_b1", 32'(if1.Data_B), 32'h1F05);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/adc_spi_rx.md
ADC_SPI_RX -- requirements
Module: adc_spi_rx

Interface
REQ-001 Parameter CLK_DIV, default 4, SHALL set the number of clk cycles per SPI_CLK half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 Init  input  1  conversion request, sampled high in IDLE.
REQ-005 SPI_MISO  input  1  serial data from ADC.
REQ-006 ADC_Conv  output  1  conversion-start strobe to ADC.
REQ-007 SPI_CLK  output  1  serial clock to ADC; idles low.
REQ-008 Data_A  output  14  channel A sample, two's complement.
REQ-009 Data_B  output  14  channel B sample, two's complement.
REQ-010 Data_Valid  output  1  one-cycle pulse; Data_A/Data_B are updated in that cycle.
REQ-011 Busy  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, CONV, SHIFT and DONE; every output SHALL be registered.
REQ-013 IDLE -> CONV on the clk edge that samples Init=1; otherwise the FSM SHALL stay in IDLE.
REQ-014 CONV SHALL hold ADC_Conv=1 for exactly 2*CLK_DIV cycles with SPI_CLK=0, then go to SHIFT.
REQ-015 SHIFT SHALL produce exactly 34 SPI_CLK periods, indexed 0..33.
- Each period is CLK_DIV cycles low, then CLK_DIV cycles high.
- ADC_Conv=0 throughout SHIFT.
REQ-016 For each period k, SPI_MISO SHALL be registered on the clk edge that drives SPI_CLK 0->1.
REQ-017 Bits k=2..15 SHALL form Data_A, MSB first; bits k=18..31 SHALL form Data_B, MSB first.
REQ-018 Bits k=0, 1, 16, 17, 32 and 33 (ADC hi-Z slots) SHALL be discarded regardless of value.
REQ-019 After the high half of period 33, the FSM SHALL enter DONE for exactly one cycle, then return to IDLE.
- In DONE: Data_Valid=1, and Data_A/Data_B take the new words.
REQ-020 Latency: Data_Valid SHALL be high in the cycle 70*CLK_DIV+1 cycles after the edge that sampled Init.
REQ-021 Data_A/Data_B SHALL hold their values between Data_Valid pulses.
REQ-022 Init while Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-023 If Init is held high, the next frame SHALL start from IDLE, giving exactly one IDLE cycle between frames.
REQ-024 The half-period counter and bit counter SHALL saturate or wrap only at their defined terminal counts; no count may exceed 2*CLK_DIV-1 or 33.
REQ-025 SPI_CLK SHALL be 0 in IDLE, CONV and DONE.

Reset
REQ-026 While rst=1 at a clk edge, the following SHALL all be 0 on that edge:
- state=IDLE, counters=0, shift register=0
- ADC_Conv, SPI_CLK, Data_A, Data_B, Data_Valid, Busy
REQ-027 rst asserted mid-frame SHALL abort the frame: no Data_Valid for it, and the first Init after rst deasserts starts a complete new frame.
REQ-028 rst SHALL take priority over Init when both are high on the same edge.

Verification
REQ-029 rst=1 for 2 cycles with Init=1 and SPI_MISO=1 -> all outputs 0 and Busy=0 throughout.
REQ-030 CLK_DIV=4, one Init pulse, ADC model drives 14'h2155 (A) and 14'h0AAA (B) with hi-Z slots=0 -> checks:
- ADC_Conv high 8 cycles
- 34 SPI_CLK rising edges
- Data_Valid single pulse 281 cycles after Init sampled
- Data_A=14'h2155, Data_B=14'h0AAA
REQ-031 Same frame with all six hi-Z slots driven 1 and data A=14'h3FFF, B=14'h0000 -> Data_A=14'h3FFF, Data_B=14'h0000.
REQ-032 Init pulsed at cycles 50 and 200 of an active frame -> exactly one Data_Valid.
- With Init then held high: frames repeat with one Busy=0 cycle between them.
REQ-033 rst asserted at SPI bit k=10 -> outputs 0 on the next edge and no Data_Valid.
- A subsequent Init yields a correct full frame (Data_A=14'h1234, Data_B=14'h2ABC).
REQ-034 CLK_DIV=1 -> SPI_CLK period 2 cycles, Data_Valid 71 cycles after Init sampled, correct data.
